hv_wdg_reg_scan: RTL and testbench
==================================

Name: hv_wdg_reg_scan

Overview:
Watchdog register-scan controller; the sole driver of the register access arbiter's lowest-priority read port.
- Periodically walks a register address window with read requests.
- Recomputes the 4-bit CRC of each returned data byte and compares it with the stored CRC.
- Flags mismatches and ack timeouts to the fault/status logic.
- Defers to OWT and SPI traffic purely through the arbiter's req/ack handshake.

Parameters:
REG_AW, 7, register address width
REG_DW, 8, register data width
REG_CRC_W, 4, stored CRC width
SCAN_START_ADDR, 7'h00, first address of scan window
SCAN_END_ADDR, 7'h3F, last address of scan window (inclusive, >= SCAN_START_ADDR)
SCAN_PERIOD_CYC, 1000, idle cycles between scan passes (>= 2)
ACK_TIMEOUT_CYC, 64, max cycles from req assert to ack before abort (>= 4)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_scan_en  in  1  level enable for scanning
i_err_clr  in  1  one-cycle pulse; clears sticky status
o_wdg_scan_rac_rd_req  out  1  read request to arbiter
o_wdg_scan_rac_addr  out  REG_AW  read address to arbiter
i_rac_wdg_scan_ack  in  1  read ack from arbiter (one cycle)
i_rac_wdg_scan_data  in  REG_DW  read data, valid with ack
i_rac_wdg_scan_crc  in  REG_CRC_W  stored CRC, valid with ack
o_scan_busy  out  1  high outside IDLE/WAIT
o_scan_done  out  1  one-cycle pulse at end of each full pass
o_scan_crc_err  out  1  one-cycle pulse per CRC mismatch
o_scan_timeout  out  1  one-cycle pulse per ack timeout
o_scan_err_sticky  out  1  set by any mismatch/timeout; cleared by i_err_clr
o_scan_err_addr  out  REG_AW  address of the first error since last clear

Behaviour:
- Reset values: all outputs 0; o_wdg_scan_rac_addr = SCAN_START_ADDR; FSM = IDLE; all counters 0.
- All outputs are registered.
- IDLE -> WAIT when i_scan_en = 1. WAIT counts SCAN_PERIOD_CYC-1 down to 0, then goes to REQ with addr = SCAN_START_ADDR.
- REQ:
  - rd_req goes high on the cycle REQ is entered and stays high until ack.
  - Address is stable while req is high.
  - On the ack cycle, data/CRC are captured and the FSM moves to CHECK. rd_req drops on the next edge, so the arbiter never regrants.
- Timeout: a counter runs while in REQ. If it reaches ACK_TIMEOUT_CYC-1 without ack:
  - rd_req drops and o_scan_timeout pulses.
  - Sticky error is set; error address is captured if the sticky flag was clear.
  - FSM moves to NEXT.
  - A late ack arriving outside REQ is ignored.
- CHECK (1 cycle):
  - Expected CRC = CRC-4, poly x^4+x+1, init 4'h0, no reflection, no final XOR, computed over the captured data MSB first.
  - On mismatch: o_scan_crc_err pulses, sticky is set, error address is captured if sticky was clear. Then go to NEXT.
- NEXT:
  - If addr == SCAN_END_ADDR: o_scan_done pulses, addr returns to SCAN_START_ADDR, go to WAIT.
  - Otherwise addr+1, go to REQ. Address never wraps past the end of the window.
- Minimum spacing between requests is 4 cycles (ack, CHECK, NEXT, REQ).
- i_scan_en low:
  - In WAIT: go to IDLE immediately.
  - In REQ/CHECK/NEXT: the outstanding access completes (ack or timeout) with normal checking, then go to IDLE. No done pulse; the next enable restarts from SCAN_START_ADDR.
- i_err_clr on the same cycle as a new error: the set wins; the error address is captured from the new error.
- An asynchronous reset mid-access drops rd_req immediately.

Optional Feature:
WDG_SCAN_ERR_HALT_EN
- Defined: a CRC mismatch or timeout moves the FSM to HALT. In HALT, rd_req = 0, o_scan_busy = 1, and no further scanning occurs. i_err_clr exits to IDLE, clearing sticky.
- Not defined: HALT does not exist and scanning continues after errors.

Test Plan:
1. Window 0x00..0x03, period 10, every ack 3 cycles after req with correct CRC -> reads 0..3 in order; rd_req drops on the edge after each ack; o_scan_done pulses once; next pass starts 10 cycles later; no errors.
2. Addr 0x02 returns data 8'hA5 with CRC 4'h0 (expected 4'hB) -> o_scan_crc_err pulses once; sticky = 1; err_addr = 0x02; a later mismatch at 0x03 leaves err_addr = 0x02; i_err_clr clears sticky.
3. No ack at addr 0x01 for 64 cycles -> o_scan_timeout pulses at cycle 64; rd_req drops; scan resumes at 0x02; a late ack is ignored.
4. Arbiter holds the grant off for 30 cycles (SPI busy) -> rd_req and address stay constant for 30 cycles with no timeout; the access completes normally.
5. i_scan_en drops while req is outstanding at 0x05 -> req held until ack, CRC checked, FSM goes to IDLE; re-enable restarts at 0x00 after the period.
6. WDG_SCAN_ERR_HALT_EN defined, mismatch at 0x01 -> no request for 0x02; busy = 1 until i_err_clr; then IDLE and a restart from 0x00.

Source files
------------

// File: rtl/hv_wdg_reg_scan.sv
// Watchdog register-scan controller: walks a register window through the arbiter's
// low-priority read port and CRC-checks each byte. Optional macro: WDG_SCAN_ERR_HALT_EN.
module hv_wdg_reg_scan #(
  parameter int                REG_AW          = 7,
  parameter int                REG_DW          = 8,
  parameter int                REG_CRC_W       = 4,
  parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
  parameter int                SCAN_PERIOD_CYC = 1000,
  parameter int                ACK_TIMEOUT_CYC = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scan_en,
  input  logic                 i_err_clr,
  output logic                 o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
  input  logic                 i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
  output logic                 o_scan_busy,
  output logic                 o_scan_done,
  output logic                 o_scan_crc_err,
  output logic                 o_scan_timeout,
  output logic                 o_scan_err_sticky,
  output logic [REG_AW-1:0]    o_scan_err_addr
);

  localparam int WAIT_W = $clog2(SCAN_PERIOD_CYC);
  localparam int TO_W   = $clog2(ACK_TIMEOUT_CYC);
  localparam logic [REG_CRC_W-1:0] CRC_POLY = {{(REG_CRC_W-2){1'b0}}, 2'b11};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REQ   = 3'd2,
    ST_CHECK = 3'd3,
    ST_NEXT  = 3'd4
`ifdef WDG_SCAN_ERR_HALT_EN
    , ST_HALT = 3'd5
`endif
  } state_t;

  state_t                state_r;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic [REG_DW-1:0]     data_r;
  logic [REG_CRC_W-1:0]  crc_r;
  logic                  crc_err_s;
  logic                  timeout_s;
  logic                  err_set_s;

  // CRC-4 x^4+x+1, init 0, MSB first, no reflection or final XOR
  function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [REG_DW-1:0] d);
    logic [REG_CRC_W-1:0] c;
    logic                 fb;
    c = '0;
    for (int i = REG_DW - 1; i >= 0; i--) begin
      fb = c[REG_CRC_W-1] ^ d[i];
      c  = {c[REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {REG_CRC_W{1'b0}});
    end
    return c;
  endfunction

  assign crc_err_s = (state_r == ST_CHECK) && (crc_calc(data_r) != crc_r);
  assign timeout_s = (state_r == ST_REQ) && !i_rac_wdg_scan_ack &&
                     (to_cnt_r == TO_W'(ACK_TIMEOUT_CYC - 1));
  assign err_set_s = crc_err_s | timeout_s;

  // Scan sequencer with registered request, address and status pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r               <= ST_IDLE;
      wait_cnt_r            <= '0;
      to_cnt_r              <= '0;
      data_r                <= '0;
      crc_r                 <= '0;
      o_wdg_scan_rac_rd_req <= 1'b0;
      o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
      o_scan_busy           <= 1'b0;
      o_scan_done           <= 1'b0;
      o_scan_crc_err        <= 1'b0;
      o_scan_timeout        <= 1'b0;
    end else begin
      o_scan_done    <= 1'b0;
      o_scan_crc_err <= crc_err_s;
      o_scan_timeout <= timeout_s;
      case (state_r)
        ST_IDLE: begin
          o_scan_busy         <= 1'b0;
          o_wdg_scan_rac_addr <= SCAN_START_ADDR;
          if (i_scan_en) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= WAIT_W'(SCAN_PERIOD_CYC - 1);
          end
        end
        ST_WAIT: begin
          if (!i_scan_en) begin
            state_r <= ST_IDLE;
          end else if (wait_cnt_r == '0) begin
            state_r               <= ST_REQ;
            o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
            o_wdg_scan_rac_rd_req <= 1'b1;
            o_scan_busy           <= 1'b1;
            to_cnt_r              <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
          end
        end
        ST_REQ: begin
          if (i_rac_wdg_scan_ack) begin
            data_r                <= i_rac_wdg_scan_data;
            crc_r                 <= i_rac_wdg_scan_crc;
            o_wdg_scan_rac_rd_req <= 1'b0;
            state_r               <= ST_CHECK;
          end else if (timeout_s) begin
            o_wdg_scan_rac_rd_req <= 1'b0;
`ifdef WDG_SCAN_ERR_HALT_EN
            state_r               <= ST_HALT;
`else
            state_r               <= ST_NEXT;
`endif
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        ST_CHECK: begin
`ifdef WDG_SCAN_ERR_HALT_EN
          state_r <= crc_err_s ? ST_HALT : ST_NEXT;
`else
          state_r <= ST_NEXT;
`endif
        end
        ST_NEXT: begin
          if (!i_scan_en) begin
            state_r             <= ST_IDLE;
            o_scan_busy         <= 1'b0;
            o_wdg_scan_rac_addr <= SCAN_START_ADDR;
          end else if (o_wdg_scan_rac_addr == SCAN_END_ADDR) begin
            state_r             <= ST_WAIT;
            o_scan_busy         <= 1'b0;
            o_scan_done         <= 1'b1;
            o_wdg_scan_rac_addr <= SCAN_START_ADDR;
            wait_cnt_r          <= WAIT_W'(SCAN_PERIOD_CYC - 1);
          end else begin
            state_r               <= ST_REQ;
            o_wdg_scan_rac_addr   <= o_wdg_scan_rac_addr + REG_AW'(1);
            o_wdg_scan_rac_rd_req <= 1'b1;
            to_cnt_r              <= '0;
          end
        end
`ifdef WDG_SCAN_ERR_HALT_EN
        ST_HALT: begin
          o_wdg_scan_rac_rd_req <= 1'b0;
          if (i_err_clr) begin
            state_r             <= ST_IDLE;
            o_scan_busy         <= 1'b0;
            o_wdg_scan_rac_addr <= SCAN_START_ADDR;
          end
        end
`endif
        default: begin
          state_r               <= ST_IDLE;
          o_wdg_scan_rac_rd_req <= 1'b0;
          o_scan_busy           <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear and takes the address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_scan_err_sticky <= 1'b0;
      o_scan_err_addr   <= '0;
    end else if (err_set_s) begin
      o_scan_err_sticky <= 1'b1;
      if (!o_scan_err_sticky || i_err_clr) begin
        o_scan_err_addr <= o_wdg_scan_rac_addr;
      end
    end else if (i_err_clr) begin
      o_scan_err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// Scoreboard bench for hv_wdg_reg_scan: a behavioural arbiter answers read requests,
// expected addresses and error events are queued and compared as the DUT produces them.
module tb_hv_wdg_reg_scan;
  localparam int AW = 7, DW = 8, CW = 4, END_A = 7, PERIOD = 10, TMO = 64;

  logic          clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, err_clr = 1'b0, ack = 1'b0;
  logic [DW-1:0] rdata = 8'h00;
  logic [CW-1:0] rcrc = 4'h0;
  logic          rd_req, busy, done, crc_err, timeout, sticky;
  logic [AW-1:0] addr, err_addr;

  hv_wdg_reg_scan #(
    .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CW),
    .SCAN_START_ADDR(7'h00), .SCAN_END_ADDR(7'h07),
    .SCAN_PERIOD_CYC(PERIOD), .ACK_TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .i_err_clr(err_clr),
    .o_wdg_scan_rac_rd_req(rd_req), .o_wdg_scan_rac_addr(addr),
    .i_rac_wdg_scan_ack(ack), .i_rac_wdg_scan_data(rdata), .i_rac_wdg_scan_crc(rcrc),
    .o_scan_busy(busy), .o_scan_done(done), .o_scan_crc_err(crc_err),
    .o_scan_timeout(timeout), .o_scan_err_sticky(sticky), .o_scan_err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, done_cnt = 0;
  logic [DW-1:0] mem_data [128];
  logic [CW-1:0] mem_crc  [128];
  int            ack_lat  [128];   // cycles from req to ack; 0 = never ack
  int addr_q[$], crcerr_q[$], to_q[$];

  // Reference CRC by long division of d*x^4 by 10011
  function automatic logic [3:0] ref_crc(input logic [7:0] d);
    logic [11:0] r;
    r = {d, 4'h0};
    for (int i = 11; i >= 4; i--) if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [7:0] init_data(input int a);
    return 8'(a * 37 + 5);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_pass(input int last);
    for (int a = 0; a <= last; a++) addr_q.push_back(a);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 3000);
    chk({tag, "_done_seen"}, int'(done), 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("sticky_cleared", int'(sticky), 0);
  endtask

  // Behavioural arbiter: answers each request after ack_lat cycles
  initial begin : arb
    int  a, n, lat;
    bit  moved;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        a = int'(addr); lat = ack_lat[a]; n = 1; moved = 1'b0;
        if (addr_q.size() == 0) chk("unexpected_req", a, -1);
        else chk("req_addr", a, addr_q.pop_front());
        chk("busy_in_req", int'(busy), 1);
        if (lat == 0) to_q.push_back(a);
        while (rd_req && (lat == 0 || n < lat) && n < 300) begin
          @(negedge clk);
          if (rd_req) begin
            n++;
            if (int'(addr) != a) moved = 1'b1;
          end
        end
        chk("addr_stable", int'(moved), 0);
        if (rd_req && lat != 0 && n >= lat) begin
          rdata = mem_data[a]; rcrc = mem_crc[a]; ack = 1'b1;
          if (ref_crc(mem_data[a]) != mem_crc[a]) crcerr_q.push_back(a);
          @(negedge clk);
          ack = 1'b0;
          chk("req_drop_after_ack", int'(rd_req), 0);
        end else if (lat == 0) begin
          chk("timeout_pulse", int'(timeout), 1);
          chk("timeout_cycles", n, TMO);
          rdata = 8'h00; rcrc = 4'hF; ack = 1'b1;   // late ack, must be ignored
          @(posedge clk);
          #1 ack = 1'b0;
        end else begin
          chk("req_held_until_ack", n, lat);
        end
      end
    end
  end

  // Output monitor: pops expected error events and counts passes
  initial begin : mon
    forever begin
      @(negedge clk);
      if (crc_err) begin
        if (crcerr_q.size() == 0) chk("unexpected_crc_err", int'(addr), -1);
        else chk("crc_err_addr", int'(addr), crcerr_q.pop_front());
      end
      if (timeout) begin
        if (to_q.size() == 0) chk("unexpected_timeout", int'(addr), -1);
        else chk("timeout_addr", int'(addr), to_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_addr_restart", int'(addr), 0);
      end
    end
  end

  initial begin : main
    int k, dc;
    for (int a = 0; a < 128; a++) begin
      mem_data[a] = init_data(a);
      mem_crc[a]  = ref_crc(mem_data[a]);
      ack_lat[a]  = 3;
    end
    ack_lat[6] = 30;   // arbiter busy with other traffic
    repeat (3) @(negedge clk);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_crc_err", int'(crc_err), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_sticky", int'(sticky), 0);
    chk("rst_err_addr", int'(err_addr), 0);
    rst_n = 1'b1;

    // Pass 1: clean scan with one long grant delay
    push_pass(END_A);
    scan_en = 1'b1;
    wait_done("pass1");
    chk("pass1_sticky", int'(sticky), 0);

    // Pass 2: bad CRC at 0x02 and 0x03
    push_pass(END_A);
    mem_data[2] = 8'hA5; mem_crc[2] = 4'h0;
    mem_crc[3]  = ref_crc(mem_data[3]) ^ 4'h1;
    ack_lat[6]  = 3;
    k = 0;
    do begin @(negedge clk); k++; end while (!rd_req && k < 100);
    chk("pass_gap", k, PERIOD);
    wait_done("pass2");
    chk("pass2_sticky", int'(sticky), 1);
    chk("pass2_err_addr", int'(err_addr), 2);
    pulse_clr();

    // Pass 3: no ack at 0x01
    mem_data[2] = init_data(2); mem_crc[2] = ref_crc(mem_data[2]);
    mem_crc[3]  = ref_crc(mem_data[3]);
    ack_lat[1]  = 0;
    push_pass(END_A);
    wait_done("pass3");
    chk("pass3_sticky", int'(sticky), 1);
    chk("pass3_err_addr", int'(err_addr), 1);
    pulse_clr();
    ack_lat[1] = 3;

    // Pass 4: disable while the access at 0x05 is outstanding
    mem_crc[5] = ref_crc(mem_data[5]) ^ 4'h2;
    push_pass(5);
    k = 0;
    do begin @(negedge clk); k++; end while (!(rd_req && addr == 7'h05) && k < 500);
    chk("req5_seen", int'(rd_req && addr == 7'h05), 1);
    scan_en = 1'b0;
    dc = done_cnt;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_rd_req", int'(rd_req), 0);
    chk("idle_no_done", done_cnt, dc);
    chk("idle_addr", int'(addr), 0);
    chk("pass4_reqs_left", addr_q.size(), 0);
    chk("pass4_err_addr", int'(err_addr), 5);
    pulse_clr();

    // Pass 5: re-enable restarts from the window start after the period
    mem_crc[5] = ref_crc(mem_data[5]);
    push_pass(END_A);
    scan_en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!rd_req && k < 100);
    chk("restart_gap", k, PERIOD + 1);
    wait_done("pass5");
    chk("end_addr_q", addr_q.size(), 0);
    chk("end_crcerr_q", crcerr_q.size(), 0);
    chk("end_to_q", to_q.size(), 0);
    chk("end_done_cnt", done_cnt, 4);
    chk("end_sticky", int'(sticky), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
